// File: rtl/param_sum_processor_if.sv
// Handshake and result bundle for param_sum_processor.
// The requester (master) drives start/limit; the processor (slave) returns
// the registered result together with busy/done/overflow status.
interface param_sum_processor_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  limit;
    logic [DATA_W-1:0] outport;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output start,
        output limit,
        input  outport,
        input  busy,
        input  done,
        input  overflow
    );

    modport slave (
        input  start,
        input  limit,
        output outport,
        output busy,
        output done,
        output overflow
    );
endinterface

// File: rtl/param_sum_processor.sv
// param_sum_processor: computes sum(i, i = 1..limit) modulo 2^DATA_W.
// limit is latched when start is accepted in S_IDLE; the result lands in
// outport, done pulses for one cycle, overflow is sticky for the run.
// Optional build macro PSP_LIVE_OUT_EN: outport also shows the running sum
// during the loop (cleared at run start); final value and timing unchanged.
//
// state   | meaning
// S_IDLE  | waiting for start, outport/overflow hold
// S_INIT  | clear sum and overflow, i = 1
// S_CHECK | compare i <= lim, pick S_ADD or S_OUT
// S_ADD   | sum += i, i += 1, accumulate carry into overflow
// S_OUT   | copy sum into outport
// S_DONE  | done high for this single cycle
module param_sum_processor #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    param_sum_processor_if.slave  bus
);

    // i is one bit wider than limit so it can reach limit+1 without wrapping.
    localparam int IW = CNT_W + 1;
    // Common width for inspecting the bits of i above the adder width.
    localparam int XW = (IW > DATA_W) ? IW : DATA_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sum_q,   sum_d;
    logic [IW-1:0]     i_q,     i_d;
    logic [CNT_W-1:0]  lim_q,   lim_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              ovf_q,   ovf_d;

    logic [XW-1:0]     i_ext;
    logic              i_hi;
    logic              i_le;
    logic [DATA_W:0]   add_full;
    logic              carry;

    // Adder and loop compare: only the low DATA_W bits of i feed the adder,
    // anything set above them is already an overflow in its own right.
    always_comb begin
        i_ext    = XW'(i_q);
        i_hi     = |(i_ext >> DATA_W);
        add_full = {1'b0, sum_q} + {1'b0, i_ext[DATA_W-1:0]};
        carry    = add_full[DATA_W] | i_hi;
        i_le     = (i_q <= {1'b0, lim_q});
    end

    // Next-state and datapath control; outputs are derived from the next
    // state so busy/done are registered and line up with the state register.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        i_d     = i_q;
        lim_d   = lim_q;
        out_d   = out_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lim_d   = bus.limit;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                sum_d   = '0;
                i_d     = {{(IW-1){1'b0}}, 1'b1};
                ovf_d   = 1'b0;
`ifdef PSP_LIVE_OUT_EN
                out_d   = '0;
`endif
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = i_le ? S_ADD : S_OUT;
            end
            S_ADD: begin
                sum_d   = add_full[DATA_W-1:0];
                i_d     = i_q + {{(IW-1){1'b0}}, 1'b1};
                ovf_d   = ovf_q | carry;
`ifdef PSP_LIVE_OUT_EN
                out_d   = add_full[DATA_W-1:0];
`endif
                state_d = S_CHECK;
            end
            S_OUT: begin
                out_d   = sum_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            i_q     <= '0;
            lim_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            i_q     <= i_d;
            lim_q   <= lim_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.outport  = out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/param_sum_processor.md
Name: param_sum_processor

Overview:
- Parametrised successor to the fixed 1..10 summing processor: computes sum of i for i = 1..limit, with the run-time limit latched on a start pulse.
- Internally a control FSM drives a datapath with a counter register, an accumulator register and an output register. Results have parametrised width.
- Adds a start/busy/done handshake and a sticky overflow flag. Sits under the top level and drives the board output port.

Parameters:
- DATA_W, 8, width of accumulator and outport; sum wraps modulo 2^DATA_W.
- CNT_W, 8, width of limit input. The internal counter i is CNT_W+1 bits, so it never wraps before exceeding limit.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- start  in  1  request a run; sampled only in S_IDLE.
- limit  in  CNT_W  upper bound N of the summation; latched when start is accepted.
- outport  out  DATA_W  result register; holds the last completed result.
- busy  out  1  high in every state except S_IDLE.
- done  out  1  one-cycle pulse when outport has just been updated.
- overflow  out  1  sticky per run: set if any addition carried out of DATA_W.

Behaviour:
- Reset (async, reset=0):
  - state=S_IDLE; sum=0; i=0; lim=0.
  - outport=0, busy=0, done=0, overflow=0.
- States: S_IDLE, S_INIT, S_CHECK, S_ADD, S_OUT, S_DONE. One transition per clk edge.
- S_IDLE:
  - If start=1: lim<=limit, then go to S_INIT.
  - Otherwise stay. outport and overflow hold.
- S_INIT: sum<=0, i<=1, overflow<=0, then go to S_CHECK.
- S_CHECK (combinational compare i<=lim, the iLe flag):
  - If true, go to S_ADD.
  - Else go to S_OUT.
- S_ADD:
  - sum<=(sum+i) mod 2^DATA_W, i<=i+1.
  - overflow<=overflow | carry-out, where carry-out means sum+i >= 2^DATA_W. Only the low DATA_W bits of i enter the adder; any set high bits of i also count as carry-out.
  - Then go to S_CHECK.
- S_OUT: outport<=sum, then go to S_DONE.
- S_DONE: done=1 for exactly this cycle, then go to S_IDLE.
- Latency:
  - Start sampled at edge E0. outport is updated at edge E(3+2N); done is high in the cycle after E(3+2N).
  - The next start is accepted at edge E(5+2N) at the earliest.
  - N=0 gives outport=0 with done after E3.
- start while busy=1: ignored, not queued.
- limit changes during a run: no effect; lim is latched.
- start held high continuously: a new run starts on each return to S_IDLE (back-to-back runs).
- Reset asserted mid-run:
  - Immediate return to S_IDLE with all registers cleared.
  - No done pulse.
  - outport=0.
- N=2^CNT_W-1: i reaches 2^CNT_W without wrap and the loop terminates correctly.
- Illegal state encoding: go to S_IDLE.

Optional Feature:
- Macro: PSP_LIVE_OUT_EN.
- Defined:
  - outport<=next sum is also written in every S_ADD cycle, so the display shows the running sum.
  - S_INIT also clears outport to 0.
  - The final value and done timing are unchanged.
- Undefined: outport changes only in S_OUT (and on reset).

Test Plan:
- Reset then start with limit=10 (DATA_W=8) -> done pulse 1 cycle after E23; outport=55, overflow=0, busy=0 after done.
- limit=0 -> done after E3; outport=0, overflow=0.
- limit=22 -> outport=253, overflow=0. Then limit=23 -> outport=20 (276 mod 256), overflow=1. Then limit=4 -> outport=10, overflow cleared to 0.
- Pulse start again mid-run and change limit from 10 to 3 mid-run -> ignored; result 55 with unchanged timing.
- Assert reset during S_ADD at iteration 5 -> outport=0, busy=0, done never pulses. Then start with limit=10 -> 55.
- With PSP_LIVE_OUT_EN, limit=4 -> outport sequence 0,1,3,6,10, each change one cycle after an S_ADD edge. Without the macro, outport holds the previous result until it jumps to 10.
